// File: rtl/coordinate_sequencer_2d.sv
// Walks window origins over a WxH map per channel, emitting (row, col, ch) and a linear address under valid/ready.
// Optional macro COORD_SEQ_ADDR_EN builds the address datapath; otherwise o_addr is tied to 0.
module coordinate_sequencer_2d #(
    parameter int ADDR_WIDTH = 8,
    parameter int CH_WIDTH   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_reg_clear,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_o_width,
    input  logic [ADDR_WIDTH-1:0] i_o_height,
    input  logic [ADDR_WIDTH-1:0] i_stride,
    input  logic [CH_WIDTH-1:0]   i_num_ch,
    input  logic [ADDR_WIDTH-1:0] i_i_width,
    input  logic [ADDR_WIDTH-1:0] i_start_addr,
    input  logic                  i_ready,
    output logic [ADDR_WIDTH-1:0] o_o_x,
    output logic [ADDR_WIDTH-1:0] o_o_y,
    output logic [CH_WIDTH-1:0]   o_ch,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_valid,
    output logic                  o_last,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;
    localparam logic [CH_WIDTH-1:0]   C_ONE = 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] w_q, h_q, s_q;
    logic [CH_WIDTH-1:0]   c_q;
    logic [ADDR_WIDTH-1:0] col_idx, row_idx, x_q, y_q;
    logic [CH_WIDTH-1:0]   ch_q;

    logic start_ok, zero_size, fire, col_end, row_end, ch_end, is_last;

    assign start_ok  = i_start && (state != RUN);
    assign zero_size = (i_o_width == '0) || (i_o_height == '0) || (i_num_ch == '0);
    assign fire      = (state == RUN) && i_ready;
    // Index counters keep the end-of-loop compare free of any multiply.
    assign col_end   = col_idx == (w_q - A_ONE);
    assign row_end   = row_idx == (h_q - A_ONE);
    assign ch_end    = ch_q == (c_q - C_ONE);
    assign is_last   = col_end && row_end && ch_end;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (i_start) state_nxt = zero_size ? DONE : RUN;
            RUN:        if (i_ready && is_last) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
        if (i_reg_clear) state_nxt = IDLE;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            w_q <= '0; h_q <= '0; s_q <= '0; c_q <= '0;
            col_idx <= '0; row_idx <= '0; x_q <= '0; y_q <= '0; ch_q <= '0;
        end else if (i_reg_clear) begin
            w_q <= '0; h_q <= '0; s_q <= '0; c_q <= '0;
            col_idx <= '0; row_idx <= '0; x_q <= '0; y_q <= '0; ch_q <= '0;
        end else if (start_ok) begin
            w_q <= i_o_width; h_q <= i_o_height; s_q <= i_stride; c_q <= i_num_ch;
            col_idx <= '0; row_idx <= '0; x_q <= '0; y_q <= '0; ch_q <= '0;
        end else if (fire) begin
            if (is_last) begin
                col_idx <= '0; row_idx <= '0; x_q <= '0; y_q <= '0; ch_q <= '0;
            end else if (!col_end) begin
                col_idx <= col_idx + A_ONE;
                y_q     <= y_q + s_q;
            end else begin
                col_idx <= '0;
                y_q     <= '0;
                if (!row_end) begin
                    row_idx <= row_idx + A_ONE;
                    x_q     <= x_q + s_q;
                end else begin
                    row_idx <= '0;
                    x_q     <= '0;
                    ch_q    <= ch_q + C_ONE;
                end
            end
        end
    end

    assign o_valid = (state == RUN);
    assign o_busy  = (state == RUN);
    assign o_done  = (state == DONE);
    assign o_last  = o_valid && is_last;
    assign o_o_x   = x_q;
    assign o_o_y   = y_q;
    assign o_ch    = ch_q;

`ifdef COORD_SEQ_ADDR_EN
    logic [ADDR_WIDTH-1:0]   iw_q, sa_q;
    logic [2*ADDR_WIDTH-1:0] prod, addr_full;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            iw_q <= '0; sa_q <= '0;
        end else if (i_reg_clear) begin
            iw_q <= '0; sa_q <= '0;
        end else if (start_ok) begin
            iw_q <= i_i_width; sa_q <= i_start_addr;
        end
    end

    assign prod      = {{ADDR_WIDTH{1'b0}}, x_q} * {{ADDR_WIDTH{1'b0}}, iw_q};
    assign addr_full = prod + {{ADDR_WIDTH{1'b0}}, sa_q} + {{ADDR_WIDTH{1'b0}}, y_q};
    // Gated so the stale base address never shows outside RUN.
    assign o_addr    = o_valid ? addr_full[ADDR_WIDTH-1:0] : '0;
`else
    logic unused_addr_in;
    assign unused_addr_in = ^{i_i_width, i_start_addr};
    assign o_addr = '0;
`endif

endmodule
